ram_tester: RTL and testbench

RAM_TESTER -- requirements
Module: ram_tester

---
 rtl/ram_tester_pkg.sv | 30 +++
 rtl/bus_timer.sv | 42 ++++
 rtl/ram_tester.sv | 176 +++++++++++++++++
 tb/tb_ram_tester.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_tester_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_tester_pkg
// Description : Shared definitions for the RAM tester: FSM state encoding,
//               bus widths, default pattern seed and the pattern function.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_tester_pkg;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 32;

    typedef logic [ADDR_W-1:0] word_addr_t;
    typedef logic [DATA_W-1:0] word_data_t;

    // Tester FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WR   = 2'd1;
    localparam logic [1:0] ST_RD   = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    localparam logic [31:0] SEED_DEFAULT = 32'hA5A5_5A5A;

    // Address-dependent test pattern: zero-extended word address XOR seed
    function automatic word_data_t pat(input word_addr_t a, input word_data_t seed);
        return {7'b0, a} ^ seed;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_timer.sv
`default_nettype none
// ============================================================================
// Module      : bus_timer
// Description : Per-transaction ack watchdog for a bus initiator. Counts the
//               cycles a request is outstanding without ack and flags expiry
//               in the cycle the count reaches TIMEOUT. An ack in that same
//               cycle wins over expiry.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic ack,
    output logic expired
);

    // Counter only needs to hold 0 .. TIMEOUT-1; expiry fires on the
    // cycle that would take it to TIMEOUT.
    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    // Cleared while idle or on ack, counts waiting cycles, saturates at last value
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (!run || ack) begin
            r_cnt <= '0;
        end else if (r_cnt != C_LAST) begin
            r_cnt <= r_cnt + C_ONE;
        end
    end

    assign expired = run & ~ack & (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/ram_tester.sv
`default_nettype none
// ============================================================================
// Module      : ram_tester
// Description : Built-in RAM tester. Writes an address-derived pattern over a
//               word range, reads it back and compares, reporting pass/fail,
//               first failing address/data, and ack timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_tester
    import ram_tester_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter logic [31:0] SEED    = SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [24:0] base,
    input  logic [24:0] count,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [24:0] err_addr,
    output logic [31:0] err_data,
    output logic        stb,
    output logic        we,
    output logic [24:0] addr,
    output logic [31:0] data_out,
    input  logic [31:0] data_in,
    input  logic        ack
);

    localparam logic [24:0] C_ONE = 25'd1;

    logic [1:0]  r_state;
    logic [24:0] r_base;
    logic [24:0] r_count;
    logic [24:0] r_left;

    logic w_expired;
    logic w_last;
    logic w_rd_ok;

    assign w_last  = (r_left == C_ONE);
    assign w_rd_ok = (data_in == pat(addr, SEED));

    bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_bus_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (stb),
        .ack     (ack),
        .expired (w_expired)
    );

    // Test sequencer: start sampling, write pass, read/compare pass, result
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_base   <= '0;
            r_count  <= '0;
            r_left   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            timeout  <= 1'b0;
            err_addr <= '0;
            err_data <= '0;
            stb      <= 1'b0;
            we       <= 1'b0;
            addr     <= '0;
            data_out <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        timeout  <= 1'b0;
                        err_addr <= '0;
                        err_data <= '0;
                        pass     <= 1'b0;
                        r_base   <= base;
                        r_count  <= count;
                        r_left   <= count;
                        addr     <= base;
                        if (count == '0) begin
                            // Empty range trivially passes
                            pass    <= 1'b1;
                            done    <= 1'b1;
                            r_state <= ST_FIN;
                        end else begin
                            stb      <= 1'b1;
                            we       <= 1'b1;
                            data_out <= pat(base, SEED);
                            r_state  <= ST_WR;
                        end
                    end
                end

                ST_WR: begin
                    if (stb) begin
                        if (ack) begin
                            stb <= 1'b0;
                            if (w_last) begin
                                r_left  <= r_count;
                                addr    <= r_base;
                                r_state <= ST_RD;
                            end else begin
                                r_left <= r_left - C_ONE;
                                addr   <= addr + C_ONE;
                            end
                        end else if (w_expired) begin
                            stb      <= 1'b0;
                            timeout  <= 1'b1;
                            pass     <= 1'b0;
                            err_addr <= addr;
                            done     <= 1'b1;
                            r_state  <= ST_FIN;
                        end
                    end else begin
                        // One idle bus cycle after every ack before the next request
                        stb      <= 1'b1;
                        we       <= 1'b1;
                        data_out <= pat(addr, SEED);
                    end
                end

                ST_RD: begin
                    if (stb) begin
                        if (ack) begin
                            stb <= 1'b0;
                            if (!w_rd_ok) begin
                                err_addr <= addr;
                                err_data <= data_in;
                                pass     <= 1'b0;
                                done     <= 1'b1;
                                r_state  <= ST_FIN;
                            end else if (w_last) begin
                                pass    <= 1'b1;
                                done    <= 1'b1;
                                r_state <= ST_FIN;
                            end else begin
                                r_left <= r_left - C_ONE;
                                addr   <= addr + C_ONE;
                            end
                        end else if (w_expired) begin
                            stb      <= 1'b0;
                            timeout  <= 1'b1;
                            pass     <= 1'b0;
                            err_addr <= addr;
                            done     <= 1'b1;
                            r_state  <= ST_FIN;
                        end
                    end else begin
                        stb <= 1'b1;
                        we  <= 1'b0;
                    end
                end

                ST_FIN: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_tester.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_tester
// Description : Self-checking bench for ram_tester with a wait-state RAM
//               model, directed vector table, timeout/reset sequences and
//               randomized runs against a behavioural reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_tester;

    localparam int unsigned TO = 8;
    localparam logic [31:0] C_SEED = 32'hA5A5_5A5A;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [24:0] base = '0;
    logic [24:0] count = '0;
    logic [31:0] data_in = '0;
    logic        ack = 1'b0;
    logic        busy, done, pass, timeout, stb, we;
    logic [24:0] err_addr, addr;
    logic [31:0] err_data, data_out;

    ram_tester #(.TIMEOUT(TO), .SEED(C_SEED)) dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .count(count),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_addr(err_addr), .err_data(err_data), .stb(stb), .we(we),
        .addr(addr), .data_out(data_out), .data_in(data_in), .ack(ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [24:0] a;
        logic [31:0] d;
    } txn_t;

    typedef struct {
        logic [24:0] base;
        logic [24:0] cnt;
        int          wmax;
        bit          cor;
        logic [24:0] caddr;
        bit          restart;
        bit          exp_pass;
        logic [24:0] exp_ea;
        logic [31:0] exp_ed;
        int          exp_ntx;
    } vec_t;

    txn_t log_q[$];
    txn_t exp_q[$];
    txn_t t_tmp;
    logic [31:0] mem [logic [24:0]];

    int          wmin = 0, wmax = 0;
    bit          never_ack = 0, cor_en = 0, chk_en = 1;
    logic [24:0] cor_addr = '0;
    int          stab_errs = 0, stb_hi = 0;
    bit          in_txn = 0;
    int          wcnt = 0, wtgt = 0;
    logic        p_stb = 0, p_ack = 0, p_we = 0;
    logic [24:0] p_addr = '0;
    logic [31:0] p_dout = '0;

    int n_cmp = 0, n_fail = 0;

    function automatic logic [31:0] exp_pat(input logic [24:0] a);
        return {7'b0, a} ^ C_SEED;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // RAM model with random wait states, plus bus-protocol monitor
    always @(negedge clk) begin
        if (chk_en) begin
            if (p_stb && p_ack && stb) stab_errs++;
            if (p_stb && !p_ack && !done &&
                (stb !== 1'b1 || we !== p_we || addr !== p_addr || data_out !== p_dout))
                stab_errs++;
        end
        if (stb) stb_hi++;
        ack = 1'b0;
        if (stb === 1'b1 && !never_ack) begin
            if (!in_txn) begin
                in_txn = 1;
                wcnt   = 0;
                wtgt   = $urandom_range(wmax, wmin);
            end
            if (wcnt == wtgt) begin
                ack    = 1'b1;
                in_txn = 0;
                if (we) begin
                    mem[addr] = data_out;
                    t_tmp.we = 1'b1; t_tmp.a = addr; t_tmp.d = data_out;
                end else begin
                    data_in = mem.exists(addr) ? mem[addr] : 32'h0;
                    if (cor_en && addr == cor_addr) data_in = data_in ^ 32'h1;
                    t_tmp.we = 1'b0; t_tmp.a = addr; t_tmp.d = data_in;
                end
                log_q.push_back(t_tmp);
            end else begin
                wcnt++;
            end
        end else if (stb !== 1'b1) begin
            in_txn = 0;
        end
        p_stb = stb; p_ack = ack; p_we = we; p_addr = addr; p_dout = data_out;
    end

    // Reference: expected bus transactions and result for one test
    task automatic model(input logic [24:0] b, input logic [24:0] c, input bit ce,
                         input logic [24:0] ca, output bit ep,
                         output logic [24:0] ea, output logic [31:0] ed);
        txn_t t;
        logic [24:0] a;
        exp_q.delete();
        ep = 1; ea = '0; ed = '0;
        for (int i = 0; i < int'(c); i++) begin
            a = b + 25'(i);
            t.we = 1'b1; t.a = a; t.d = exp_pat(a);
            exp_q.push_back(t);
        end
        for (int i = 0; i < int'(c); i++) begin
            a = b + 25'(i);
            t.we = 1'b0; t.a = a; t.d = '0;
            exp_q.push_back(t);
            if (ce && a == ca) begin
                ep = 0; ea = a; ed = exp_pat(a) ^ 32'h1;
                break;
            end
        end
    endtask

    task automatic run_test(input logic [24:0] b, input logic [24:0] c,
                            input int wlo, input int whi, input bit ce,
                            input logic [24:0] ca, input bit restart, output int cyc);
        bit ep, seen;
        logic [24:0] ea;
        logic [31:0] ed;
        int bad;
        model(b, c, ce, ca, ep, ea, ed);
        wmin = wlo; wmax = whi; cor_en = ce; cor_addr = ca; never_ack = 0;
        @(negedge clk);
        log_q.delete(); mem.delete(); stab_errs = 0; stb_hi = 0;
        base = b; count = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0; cyc = 1; seen = 0;
        check("busy_after_start", busy, 1);
        while (cyc < 2000) begin
            if (done) begin seen = 1; break; end
            if (restart && cyc == 3) begin
                start = 1'b1; base = b + 25'h1000; count = 25'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("done_seen", seen, 1);
        check("pass", pass, ep);
        check("timeout_flag", timeout, 0);
        check("err_addr", err_addr, ea);
        check("err_data", err_data, ed);
        check("txn_count", log_q.size(), exp_q.size());
        bad = 0;
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
            if (log_q[i].we !== exp_q[i].we || log_q[i].a !== exp_q[i].a ||
                (exp_q[i].we && log_q[i].d !== exp_q[i].d)) bad++;
        check("txn_seq", bad, 0);
        check("bus_stable", stab_errs, 0);
        @(negedge clk);
        check("done_pulse_end", done, 0);
        check("busy_end", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int cyc;
        logic [24:0] rb, rc, rca;
        bit rce;

        vecs[0] = '{25'h10,      25'd4, 0, 0, 25'h0,  0, 1, 25'h0,  32'h0,         8};
        vecs[1] = '{25'h10,      25'd4, 0, 1, 25'h12, 0, 0, 25'h12, 32'hA5A5_5A49, 7};
        vecs[2] = '{25'h1FFFFFE, 25'd3, 5, 0, 25'h0,  0, 1, 25'h0,  32'h0,         6};
        vecs[3] = '{25'h55,      25'd0, 0, 0, 25'h0,  0, 1, 25'h0,  32'h0,         0};
        vecs[4] = '{25'h200,     25'd5, 2, 0, 25'h0,  1, 1, 25'h0,  32'h0,         10};

        // Reset state
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ctrl", {stb, we, busy, done, pass, timeout}, 6'b0);
        check("rst_bus", {addr, data_out}, 57'h0);
        check("rst_err", {err_addr, err_data}, 57'h0);
        rst = 1'b1;

        // Directed vector table
        for (int i = 0; i < 5; i++) begin
            run_test(vecs[i].base, vecs[i].cnt, 0, vecs[i].wmax, vecs[i].cor,
                     vecs[i].caddr, vecs[i].restart, cyc);
            check("tbl_pass", pass, vecs[i].exp_pass);
            check("tbl_err_addr", err_addr, vecs[i].exp_ea);
            check("tbl_err_data", err_data, vecs[i].exp_ed);
            check("tbl_ntx", log_q.size(), vecs[i].exp_ntx);
            if (vecs[i].cnt == 25'd0) begin
                check("zero_cnt_latency", cyc, 1);
                check("zero_cnt_no_stb", stb_hi, 0);
            end
            if (vecs[i].base == 25'h1FFFFFE && log_q.size() > 2)
                check("wrap_addr", log_q[2].a, 25'h0);
        end

        // Timeout: RAM never acks
        never_ack = 1;
        @(negedge clk);
        log_q.delete(); stab_errs = 0; stb_hi = 0;
        base = 25'h40; count = 25'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("to_done_seen", done, 1);
        check("to_stb_cycles", stb_hi, TO);
        check("to_flag", timeout, 1);
        check("to_pass", pass, 0);
        check("to_err_addr", err_addr, 25'h40);
        check("to_no_txn", log_q.size(), 0);
        check("to_bus_stable", stab_errs, 0);
        @(negedge clk);
        never_ack = 0;

        // Reset in the middle of a write wait
        chk_en = 0;
        wmin = 3; wmax = 3;
        base = 25'h100; count = 25'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("mid_stb_high", stb, 1);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_ctrl", {stb, we, busy, done, pass, timeout}, 6'b0);
        check("mid_rst_bus", {addr, data_out}, 57'h0);
        check("mid_rst_err", {err_addr, err_data}, 57'h0);
        rst = 1'b1;
        @(negedge clk);
        chk_en = 1;
        run_test(25'h100, 25'd4, 0, 2, 0, 25'h0, 0, cyc);
        check("after_rst_pass", pass, 1);

        // Randomized runs against the reference
        for (int k = 0; k < 8; k++) begin
            rb  = 25'($urandom);
            rc  = 25'($urandom_range(6, 0));
            rce = (rc != 0) && ($urandom_range(1, 0) == 1);
            rca = (rc != 0) ? rb + 25'($urandom_range(int'(rc) - 1, 0)) : 25'h0;
            run_test(rb, rc, 0, 5, rce, rca, 0, cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
